// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM states and opcode helpers for alu_arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_INC = 4'b0011,
        OP_DEC = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SUB = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SL  = 4'b1000,
        OP_SR  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // One bit per opcode value: ADD(2), SUB(6), SL(8), SR(9) update the carry.
    localparam logic [15:0] CARRY_OPS = 16'b0000_0011_0100_0100;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    function automatic logic is_carry_op(input logic [3:0] op);
        return CARRY_OPS[op];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter_if : request, response and ALU-side signals of the arbiter|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_arbiter_if #(
    parameter int N = 4
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [N-1:0] req_a0;
    logic [N-1:0] req_a1;
    logic [N-1:0] req_b0;
    logic [N-1:0] req_b1;
    logic [3:0]   req_op0;
    logic [3:0]   req_op1;
    logic         req_flag0;
    logic         req_flag1;
    logic [1:0]   req_chain;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_flagin;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_cout;
    logic         alu_z;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_cout;
    logic         rsp_z;
    logic         rsp_err;

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
               req_flag0, req_flag1, req_chain,
        output req_ready,
        output alu_a, alu_b, alu_flagin, alu_control,
        input  alu_result, alu_cout, alu_z,
        output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1,
               req_flag0, req_flag1, req_chain,
        input  req_ready,
        input  alu_a, alu_b, alu_flagin, alu_control,
        output alu_result, alu_cout, alu_z,
        input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_z, rsp_err,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin grant; ties go to the other side    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant,
    output logic       grant_valid
);
    always_comb begin
        grant_valid = |valid;
        grant       = 1'b0;
        case (valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter : shares one ALU between two requesters, one op in flight |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    arb_state_e   r_state;
    arb_state_e   w_state_nxt;
    logic         r_rr_last;
    logic [1:0]   r_carry;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic         r_alu_flagin;
    logic [3:0]   r_alu_control;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_result;
    logic         r_rsp_cout;
    logic         r_rsp_z;
    logic         r_rsp_err;

    logic         w_gnt;
    logic         w_gnt_valid;
    logic         w_hs;
    logic [1:0]   w_req_ready;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic [3:0]   w_sel_op;
    logic         w_sel_flag;
    logic         w_sel_chain;
    logic         w_sel_fin;

    rr_arbiter2 u_rr (
        .valid       (bus.req_valid),
        .last        (r_rr_last),
        .grant       (w_gnt),
        .grant_valid (w_gnt_valid)
    );

    always_comb begin
        w_sel_a     = w_gnt ? bus.req_a1    : bus.req_a0;
        w_sel_b     = w_gnt ? bus.req_b1    : bus.req_b0;
        w_sel_op    = w_gnt ? bus.req_op1   : bus.req_op0;
        w_sel_flag  = w_gnt ? bus.req_flag1 : bus.req_flag0;
        w_sel_chain = bus.req_chain[w_gnt];
        // Carry only changes at the end of EXEC, so sampling it at grant time
        // gives the same FlagIn the ALU sees during EXEC.
        w_sel_fin   = w_sel_chain ? r_carry[w_gnt] : w_sel_flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_hs        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid && !rst) begin
                    w_req_ready[w_gnt] = 1'b1;
                    w_hs               = 1'b1;
                    w_state_nxt        = is_legal_op(w_sel_op) ? EXEC : RESP;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last     <= 1'b1;
            r_carry       <= 2'b00;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_flagin  <= 1'b0;
            r_alu_control <= 4'b0000;
            r_rsp_id      <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_cout    <= 1'b0;
            r_rsp_z       <= 1'b0;
            r_rsp_err     <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr_last <= w_gnt;
                r_rsp_id  <= w_gnt;
                if (is_legal_op(w_sel_op)) begin
                    r_alu_a       <= w_sel_a;
                    r_alu_b       <= w_sel_b;
                    r_alu_flagin  <= w_sel_fin;
                    r_alu_control <= w_sel_op;
                end else begin
                    // Illegal code never reaches the ALU; respond with an error.
                    r_rsp_result <= '0;
                    r_rsp_cout   <= 1'b0;
                    r_rsp_z      <= 1'b0;
                    r_rsp_err    <= 1'b1;
                end
            end
            if (r_state == EXEC) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_cout   <= bus.alu_cout;
                r_rsp_z      <= bus.alu_z;
                r_rsp_err    <= 1'b0;
                if (is_carry_op(r_alu_control)) begin
                    r_carry[r_rsp_id] <= bus.alu_cout;
                end
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_flagin  = r_alu_flagin;
    assign bus.alu_control = r_alu_control;
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_cout    = r_rsp_cout;
    assign bus.rsp_z       = r_rsp_z;
    assign bus.rsp_err     = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arbiter : directed vectors with a response scoreboard          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic         id;
        logic [N-1:0] res;
        logic         c;
        logic         z;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t e_mon;
    logic [N:0] alu_s;

    always #5 clk = ~clk;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference ALU the arbiter is attached to.
    always_comb begin
        alu_s          = '0;
        bus.alu_result = '0;
        bus.alu_cout   = 1'b0;
        case (bus.alu_control)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: begin
                alu_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{N{1'b0}}, bus.alu_flagin};
                bus.alu_result = alu_s[N-1:0];
                bus.alu_cout   = alu_s[N];
            end
            4'b0011: bus.alu_result = bus.alu_a + N'(1);
            4'b0100: bus.alu_result = bus.alu_a - N'(1);
            4'b0101: bus.alu_result = ~bus.alu_a;
            4'b0110: begin
                alu_s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{N{1'b0}}, bus.alu_flagin};
                bus.alu_result = alu_s[N-1:0];
                bus.alu_cout   = alu_s[N];
            end
            4'b0111: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'b1000: {bus.alu_cout, bus.alu_result} = {bus.alu_a, bus.alu_flagin};
            4'b1001: {bus.alu_result, bus.alu_cout} = {bus.alu_flagin, bus.alu_a};
            default: bus.alu_result = '0;
        endcase
        bus.alu_z = (bus.alu_result == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string msg);
        n_vec++;
        n_bad++;
        $display("FAIL %s at %0t", msg, $time);
    endtask

    // Scoreboard monitor: compares every accepted response against the queue.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                fail_now("unexpected_rsp: response with empty scoreboard");
            end else begin
                e_mon = q.pop_front();
                chk("rsp_id",     32'(bus.rsp_id),     32'(e_mon.id));
                chk("rsp_result", 32'(bus.rsp_result), 32'(e_mon.res));
                chk("rsp_cout",   32'(bus.rsp_cout),   32'(e_mon.c));
                chk("rsp_z",      32'(bus.rsp_z),      32'(e_mon.z));
                chk("rsp_err",    32'(bus.rsp_err),    32'(e_mon.err));
            end
        end
    end

    task automatic push_exp(input logic id, input logic [N-1:0] r, input logic c, z, err);
        exp_t x;
        x.id = id; x.res = r; x.c = c; x.z = z; x.err = err;
        q.push_back(x);
    endtask

    task automatic drive(input logic id, input logic [3:0] op, input logic [N-1:0] a, b,
                         input logic f, ch);
        if (id == 1'b0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; bus.req_flag0 = f;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; bus.req_flag1 = f;
        end
        bus.req_chain[id] = ch;
        bus.req_valid[id] = 1'b1;
    endtask

    task automatic wait_ready(input logic id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now($sformatf("grant_timeout: requester %0d", id));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) fail_now($sformatf("drain_timeout: %0d responses missing", q.size()));
        @(posedge clk); #1;
    endtask

    // One complete transaction with latency and ALU-drive checks.
    task automatic op1(input logic id, input logic [3:0] op, input logic [N-1:0] a, b,
                       input logic f, ch, input logic [3:0] exp_ctl, input logic exp_fin,
                       input logic [N-1:0] er, input logic ec, ez, ee);
        bit ok;
        push_exp(id, er, ec, ez, ee);
        drive(id, op, a, b, f, ch);
        wait_ready(id, ok);
        if (ok) begin
            chk("req_ready_onehot", 32'(bus.req_ready), 32'(2'b01 << id));
            @(posedge clk); #1 bus.req_valid[id] = 1'b0;
            @(negedge clk);
            if (!ee) begin
                chk("exec_alu_control", 32'(bus.alu_control), 32'(exp_ctl));
                chk("exec_alu_a",       32'(bus.alu_a),       32'(a));
                chk("exec_alu_flagin",  32'(bus.alu_flagin),  32'(exp_fin));
                chk("exec_no_rsp",      32'(bus.rsp_valid),   32'(0));
                @(negedge clk);
            end else begin
                chk("illegal_alu_control_held", 32'(bus.alu_control), 32'(exp_ctl));
            end
            chk("rsp_valid_latency", 32'(bus.rsp_valid), 32'(1));
            @(posedge clk); #1;
        end else begin
            bus.req_valid[id] = 1'b0;
            void'(q.pop_back());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int g;
        logic [1:0] r;
        logic [1:0] prev;

        rst = 1'b1;
        bus.req_valid = 2'b00; bus.req_chain = 2'b00;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        bus.req_op0 = 4'b0000; bus.req_op1 = 4'b0000;
        bus.req_flag0 = 1'b0; bus.req_flag1 = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_rsp_valid",   32'(bus.rsp_valid),   32'(0));
        chk("reset_alu_control", 32'(bus.alu_control), 32'(0));
        chk("reset_alu_a",       32'(bus.alu_a),       32'(0));
        chk("reset_rsp_result",  32'(bus.rsp_result),  32'(0));
        @(posedge clk); #1;

        // Single op, chained carry, assorted ops.
        op1(1'b0, OP_ADD, 4'h7, 4'h9, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        op1(1'b0, OP_ADD, 4'h1, 4'h2, 1'b0, 1'b1, 4'b0010, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        op1(1'b0, OP_ADD, 4'h3, 4'h4, 1'b1, 1'b1, 4'b0010, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
        op1(1'b1, OP_XOR, 4'h5, 4'h3, 1'b0, 1'b0, 4'b0111, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0);
        op1(1'b1, OP_SUB, 4'h3, 4'h5, 1'b1, 1'b0, 4'b0110, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        op1(1'b0, OP_SL,  4'h9, 4'h0, 1'b0, 1'b0, 4'b1000, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);

        // Illegal op leaves carry1 and the ALU control untouched.
        op1(1'b1, OP_ADD, 4'hF, 4'h1, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        op1(1'b1, 4'b1100, 4'h7, 4'h7, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        op1(1'b1, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);

        // Backpressure with requester 1 waiting.
        bus.rsp_ready = 1'b0;
        push_exp(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, OP_OR, 4'hA, 4'h5, 1'b0, 1'b0);
        wait_ready(1'b0, ok);
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        push_exp(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
        drive(1'b1, OP_AND, 4'hC, 4'hA, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid",  32'(bus.rsp_valid),  32'(1));
            chk("stall_rsp_result", 32'(bus.rsp_result), 32'(4'hF));
            chk("stall_rsp_id",     32'(bus.rsp_id),     32'(0));
            chk("stall_req_ready",  32'(bus.req_ready),  32'(0));
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_hs_no_grant", 32'(bus.req_ready), 32'(0));
        @(negedge clk);
        chk("grant_after_rsp", 32'(bus.req_ready), 32'(2'b10));
        @(posedge clk); #1 bus.req_valid[1] = 1'b0;
        wait_drain();

        // Contention from reset: strict alternation 0,1,0,1.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_exp(1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
        push_exp(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        push_exp(1'b0, 4'h3, 1'b0, 1'b0, 1'b0);
        push_exp(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        drive(1'b0, OP_AND, 4'hF, 4'h3, 1'b0, 1'b0);
        drive(1'b1, OP_AND, 4'h5, 4'h6, 1'b0, 1'b0);
        g = 0;
        prev = 2'b00;
        for (int i = 0; i < 60 && g < 4; i++) begin
            @(negedge clk);
            r = bus.req_ready;
            if (r != 2'b00) begin
                chk("grant_order",        32'(r),    32'((g % 2 == 0) ? 2'b01 : 2'b10));
                chk("ready_single_cycle", 32'(prev), 32'(0));
                g++;
            end
            prev = r;
        end
        if (g < 4) fail_now($sformatf("contention_timeout: %0d grants", g));
        @(posedge clk); #1 bus.req_valid = 2'b00;
        wait_drain();

        // Reset during EXEC discards the op and clears carries.
        op1(1'b0, OP_ADD, 4'h8, 4'h8, 1'b0, 1'b0, 4'b0010, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, OP_AND, 4'hF, 4'hF, 1'b0, 1'b0);
        wait_ready(1'b0, ok);
        @(posedge clk); #1 bus.req_valid[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_midop_no_rsp", 32'(bus.rsp_valid), 32'(0));
        end
        @(posedge clk); #1;
        op1(1'b0, OP_ADD, 4'h1, 4'h1, 1'b1, 1'b1, 4'b0010, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        op1(1'b1, OP_ADD, 4'h1, 4'h1, 1'b1, 1'b1, 4'b0010, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one n-bit ALU datapath between two requesters, e.g. two sequencers in the same core.
- Round-robin grant, one operation in flight, with a valid/ready handshake on request and response.
- The block drives the ALU's operand, FlagIn and 4-bit Control inputs. It registers Result/Cout/Z and keeps a per-requester carry flag so multi-word add/sub can be chained.

Parameters:
- N, 4, operand/result width; legal range 2..32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_a0, req_a1  in  N  operand A for requester 0/1.
- req_b0, req_b1  in  N  operand B for requester 0/1.
- req_op0, req_op1  in  4  ALU control code for requester 0/1.
- req_flag0, req_flag1  in  1  explicit FlagIn for requester 0/1.
- req_chain  in  2  1 = use that requester's stored carry as FlagIn instead of req_flagX.
- alu_a, alu_b  out  N  operands to the ALU.
- alu_flagin  out  1  FlagIn to the ALU.
- alu_control  out  4  Control to the ALU.
- alu_result  in  N  ALU Result.
- alu_cout  in  1  ALU Cout.
- alu_z  in  1  ALU Z.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  N  registered result.
- rsp_cout  out  1  registered carry.
- rsp_z  out  1  registered zero flag.
- rsp_err  out  1  opcode was illegal; operation not executed.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - State = IDLE; rr_last = 1, so requester 0 wins the first tie.
  - carry0 = carry1 = 0.
  - req_ready = 0; rsp_valid = 0; rsp_id/result/cout/z/err = 0.
  - alu_a/alu_b/alu_flagin = 0; alu_control = 4'b0000.
- Legal opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 INC, 0100 DEC, 0101 NOT, 0110 SUB, 0111 XOR, 1000 SL, 1001 SR.
  - 1010..1111 are illegal.
- Carry-producing opcodes: ADD, SUB, SL, SR. Package constant CARRY_OPS.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = the only valid requester. If both are valid, g = !rr_last.
  - req_ready[g] = 1 combinationally while in IDLE with req_valid[g] = 1; the other bit stays 0.
  - On handshake, capture a/b/op/flag/chain of g into operand registers and set rr_last = g.
  - Next state is EXEC if op is legal, else RESP with err = 1.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the operand registers.
  - alu_flagin = chain ? carry[g] : flag.
  - At the end of the cycle, capture alu_result/alu_cout/alu_z into the rsp registers; go to RESP.
  - If op is in CARRY_OPS, carry[g] <= alu_cout; otherwise carry[g] is unchanged.
- RESP:
  - rsp_valid = 1; rsp fields are stable until rsp_ready = 1.
  - On rsp_valid & rsp_ready, go to IDLE.
  - Back-to-back: the next grant occurs in the cycle after the response handshake.
- Latency: handshake at cycle t, then EXEC at t+1, then rsp_valid at t+2. Throughput is at most 1 op / 3 cycles.
- Outside EXEC: alu_* outputs hold their last values; they are don't-care for the ALU.
- Illegal opcode:
  - ALU is not driven with the illegal code; alu_control keeps its previous value.
  - rsp_result = 0, rsp_cout = 0, rsp_z = 0, rsp_err = 1. Carry registers are unchanged.
- Legal op: rsp_err = 0.
- Requester keeps req_valid high without being granted: the request waits and is never dropped. Fairness: two saturating requesters alternate strictly.
- Reset mid-operation (in EXEC or RESP): the in-flight op is discarded, no response is produced, and all registers return to reset values.
- Width: the block never performs arithmetic on operands; N affects register widths only. Cout is taken directly from the ALU.

Decomposition:
- Package alu_pkg:
  - opcode enum alu_op_e (10 codes above).
  - function is_legal_op; constant/function is_carry_op.
  - FSM state enum arb_state_e {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter2: 2-way round-robin grant, inputs valid[1:0] and last, output grant index plus a valid bit. Everything else lives in alu_arbiter.

Test Plan:
- Single op: reset; req0 ADD a=4'h7 b=4'h9 flag=0 -> alu_control=0010 in EXEC; at t+2 rsp_valid, rsp_id=0, result=4'h0, cout=1, z=1; carry0=1.
- Chained carry: after the above, req0 ADD a=4'h1 b=4'h2 chain=1 -> alu_flagin=1, result=4'h4, cout=0, z=0; then carry0=0.
- Contention: both requesters hold valid with AND ops for 4 grants from reset -> grant order 0,1,0,1; each ready pulse lasts one cycle; no response is lost.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and fields stable; req_ready stays 0 for both; the grant happens the cycle after rsp_ready=1.
- Illegal op: req1 op=4'b1100 -> no EXEC cycle, rsp at t+1 with err=1, result=0, cout=0, z=0; carry1 unchanged.
- Reset mid-op: assert rst in EXEC -> next cycle rsp_valid=0, carry0=carry1=0, state IDLE; a new request then gets normal 2-cycle latency.
